// File: rtl/dso_uart_pkg.sv
// Shared definitions for the DSO host UART link: command opcodes, the ack
// byte, the default bit period and the receive/transmit state encodings.
// No ports; imported by uart_cmd_slave and uart_byte_tx.
package dso_uart_pkg;

   // Host command opcodes (first byte of every 3-byte command)
   localparam logic [7:0] DUMP_CH  = 8'h01;
   localparam logic [7:0] CFG_GAIN = 8'h02;
   localparam logic [7:0] TRIG_LVL = 8'h03;
   localparam logic [7:0] TRIG_POS = 8'h04;
   localparam logic [7:0] SET_DEC  = 8'h05;
   localparam logic [7:0] TRIG_CFG = 8'h06;
   localparam logic [7:0] TRIG_RD  = 8'h07;
   localparam logic [7:0] EEP_WRT  = 8'h08;
   localparam logic [7:0] EEP_RD   = 8'h09;

   // Positive acknowledge returned to the host
   localparam logic [7:0] ACK = 8'hA5;

   // clk cycles per UART bit
   localparam int unsigned BAUD_DIV_DEFAULT = 108;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Ports: clk, rst (sync, active-high); start/data request a frame (ignored while
// busy); tx serial line (idle high); busy while framing; done pulses after stop.
module uart_byte_tx
   import dso_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned   CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

   tx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // The line value for the next bit is loaded at each bit boundary so that tx
   // is always a flop output and every bit lasts exactly BAUD_DIV cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (start) begin
               shreg_d = data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shreg_q[0];
               state_d = TX_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = TX_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/uart_cmd_slave.sv
// Device-side UART endpoint: assembles 3-byte host commands into cmd and sends
// single-byte responses. Ports: clk, rst (sync, active-high); RX/TX serial;
// cmd/cmd_rdy/clr_cmd_rdy command handoff; resp/send_resp/tx_busy/resp_sent
// response path; frame_err pulses on a low stop bit.
module uart_cmd_slave
   import dso_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV      = BAUD_DIV_DEFAULT,
   parameter int unsigned TIMEOUT_BAUDS = 32
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        tx_busy,
   output logic        resp_sent,
   output logic        frame_err
);

   localparam int unsigned   CW        = $clog2(BAUD_DIV);
   localparam int unsigned   TO_CYCLES = TIMEOUT_BAUDS * BAUD_DIV;
   localparam int unsigned   TW        = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

   // ---------------- RX synchronizer and edge detect ----------------
   logic rx_s1, rx_sync, rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= RX;
         rx_sync <= rx_s1;
         rx_prev <= rx_sync;
      end
   end

   // ---------------- receiver, assembler, timeout ----------------
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shreg_q, rx_shreg_d;
   logic          frame_err_q, frame_err_d;
   logic [23:0]   cmd_q, cmd_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          byte_vld, stop_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shreg_q  <= '0;
         frame_err_q <= 1'b0;
         cmd_q       <= '0;
         cmd_rdy_q   <= 1'b0;
         byte_cnt_q  <= '0;
         idle_cnt_q  <= '0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shreg_q  <= rx_shreg_d;
         frame_err_q <= frame_err_d;
         cmd_q       <= cmd_d;
         cmd_rdy_q   <= cmd_rdy_d;
         byte_cnt_q  <= byte_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shreg_d  = rx_shreg_q;
      frame_err_d = 1'b0;
      cmd_d       = cmd_q;
      cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
      byte_cnt_d  = byte_cnt_q;
      idle_cnt_d  = '0;
      byte_vld    = 1'b0;
      stop_bad    = 1'b0;

      // Receiver: every decision is taken when the counter reaches the middle
      // of the current bit, so the stop decision lands half-way into the stop bit.
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               // Line already back high at mid-start: treat as a glitch.
               rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shreg_d = {rx_sync, rx_shreg_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               byte_vld   = rx_sync;
               stop_bad   = ~rx_sync;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: ;
      endcase

      // Assembler. Completion is applied after the clear so that a clear in the
      // completion cycle loses; bytes are dropped while a command is pending.
      if (stop_bad) begin
         frame_err_d = 1'b1;
         byte_cnt_d  = '0;
      end else if (byte_vld && !cmd_rdy_q) begin
         case (byte_cnt_q)
            2'd0: begin
               cmd_d[23:16] = rx_shreg_q;
               byte_cnt_d   = 2'd1;
            end
            2'd1: begin
               cmd_d[15:8] = rx_shreg_q;
               byte_cnt_d  = 2'd2;
            end
            default: begin
               cmd_d[7:0] = rx_shreg_q;
               cmd_rdy_d  = 1'b1;
               byte_cnt_d = 2'd0;
            end
         endcase
      end

      // Inter-byte timeout: only a partially received command is aged.
      if (rx_state_q == RX_IDLE && byte_cnt_q != 2'd0) begin
         if (idle_cnt_q == TO_LAST) byte_cnt_d = 2'd0;
         else                       idle_cnt_d = idle_cnt_q + TW'(1);
      end
   end

   assign cmd       = cmd_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign frame_err = frame_err_q;

   // ---------------- transmitter ----------------
   uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .start (send_resp),
      .data  (resp),
      .tx    (TX),
      .busy  (tx_busy),
      .done  (resp_sent)
   );

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed + randomized bench for uart_cmd_slave with a byte-level command model.
module tb_uart_cmd_slave;

   localparam int BD  = 16;
   localparam int TOB = 32;
   localparam int TO  = TOB * BD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RX = 1'b1;
   logic        TX;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        tx_busy, resp_sent, frame_err;

   uart_cmd_slave #(.BAUD_DIV(BD), .TIMEOUT_BAUDS(TOB)) dut (
      .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .tx_busy(tx_busy), .resp_sent(resp_sent), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0, n_pass = 0, n_fail = 0;
   int   last_e0 = 0, rise_cyc = -1, fe_cnt = 0;
   logic rdy_prev = 1'b0;

   always @(negedge clk) begin
      if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rise_cyc = cyc;
      rdy_prev = cmd_rdy;
      if (frame_err === 1'b1) fe_cnt++;
   end

   // Byte-level reference model of the command assembler
   logic [7:0]  pend[$];
   logic        model_rdy = 1'b0;
   logic [23:0] model_cmd = 24'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      return f[k];
   endfunction

   task automatic model_byte(input logic [7:0] b, input logic stop);
      if (!stop) pend.delete();
      else if (!model_rdy) begin
         pend.push_back(b);
         if (pend.size() == 3) begin
            model_cmd = {pend[0], pend[1], pend[2]};
            model_rdy = 1'b1;
            pend.delete();
         end
      end
   endtask

   // Drives one serial frame; called and returns on a falling clk edge.
   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      last_e0 = cyc + 1;
      for (int j = 0; j < 10; j++) begin
         RX = (j == 9) ? stop : frame_bit(b, j);
         repeat (BD) @(negedge clk);
      end
      RX = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_rdy"}, 32'(cmd_rdy), 32'(model_rdy));
      if (model_rdy) chk({tag, "_cmd"}, 32'(cmd), 32'(model_cmd));
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic stop, input int gap);
      send_byte(b, stop, gap);
      model_byte(b, stop);
      if (gap >= TO) pend.delete();
      check_model("rx");
   endtask

   task automatic send_cmd(input logic [23:0] c);
      send_byte(c[23:16], 1'b1, 0); model_byte(c[23:16], 1'b1);
      send_byte(c[15:8],  1'b1, 0); model_byte(c[15:8],  1'b1);
      send_byte(c[7:0],   1'b1, 4); model_byte(c[7:0],   1'b1);
      check_model("cmd");
   endtask

   task automatic clear_rdy();
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      model_rdy = 1'b0;
      chk("clr_rdy", 32'(cmd_rdy), 32'd0);
   endtask

   // Sends one response starting at the current falling edge and checks the
   // whole frame; optionally fires an extra request at relative cycle 50.
   task automatic tx_frame(input logic [7:0] b, input bit second);
      logic [9:0] mid, err;
      logic       busy_bad;
      resp = b;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      mid = '0; err = '0; busy_bad = 1'b0;
      for (int r = 0; r < 10 * BD; r++) begin
         if (TX !== frame_bit(b, r / BD)) err[r / BD] = 1'b1;
         if (r % BD == BD / 2) mid[r / BD] = TX;
         if (tx_busy !== 1'b1 || resp_sent !== 1'b0) busy_bad = 1'b1;
         if (second && r == 49) begin resp = ~b; send_resp = 1'b1; end
         if (second && r == 50) send_resp = 1'b0;
         @(negedge clk);
      end
      for (int k = 0; k < 10; k++)
         chk($sformatf("tx_bit%0d", k), 32'({err[k], mid[k]}), 32'({1'b0, frame_bit(b, k)}));
      chk("tx_busy_frame", 32'(busy_bad), 32'd0);
      chk("resp_sent", 32'(resp_sent), 32'd1);
      chk("tx_busy_end", 32'(tx_busy), 32'd0);
      chk("tx_idle", 32'(TX), 32'd1);
   endtask

   initial begin
      logic [23:0] c;
      logic [7:0]  b1;
      int          e0, fe0, gap;

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(TX), 32'd1);
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_rdy", 32'(cmd_rdy), 32'd0);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_sent", 32'(resp_sent), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Basic command, latency and hold until clear
      send_cmd(24'h082ABB);
      chk("cmd_082abb", 32'(cmd), 32'h082ABB);
      chk("rdy_latency", 32'(rise_cyc), 32'(last_e0 + 2 + 9 * BD + BD / 2));
      repeat (30) @(negedge clk);
      chk("rdy_held", 32'(cmd_rdy), 32'd1);
      chk("cmd_held", 32'(cmd), 32'h082ABB);
      clear_rdy();

      // Responses: ack with an ignored mid-frame request, then back-to-back
      tx_frame(ACK_BYTE(), 1'b1);
      tx_frame(8'($urandom_range(0, 255)), 1'b0);
      @(negedge clk);
      chk("sent_pulse_1cyc", 32'(resp_sent), 32'd0);
      repeat (5) @(negedge clk);

      // Full duplex: a response and a command byte at the same time
      b1 = 8'($urandom_range(0, 255));
      fork
         tx_frame(8'($urandom_range(0, 255)), 1'b0);
         send_byte(b1, 1'b1, 0);
      join
      model_byte(b1, 1'b1);
      repeat (4) @(negedge clk);
      c = 24'($urandom);
      send_byte(c[15:8], 1'b1, 0); model_byte(c[15:8], 1'b1);
      send_byte(c[7:0], 1'b1, 4);  model_byte(c[7:0], 1'b1);
      check_model("duplex");
      clear_rdy();

      // Frame error drops the partial command
      fe0 = fe_cnt;
      rx_byte(8'h05, 1'b1, 0);
      rx_byte(8'hFF, 1'b0, 20);
      chk("ferr_once", 32'(fe_cnt - fe0), 32'd1);
      send_cmd(24'h05FF02);
      chk("cmd_05ff02", 32'(cmd), 32'h05FF02);
      clear_rdy();

      // Inter-byte timeout discards a stale first byte
      rx_byte(8'h01, 1'b1, 600);
      send_cmd(24'h07BAE0);
      chk("cmd_07bae0", 32'(cmd), 32'h07BAE0);
      clear_rdy();

      // Randomized commands with short and long inter-byte gaps
      for (int n = 0; n < 6; n++) begin
         c = 24'($urandom);
         for (int i = 2; i >= 0; i--) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 700) : $urandom_range(0, 300);
            rx_byte(c[i*8 +: 8], 1'b1, gap);
         end
         if (model_rdy) clear_rdy();
      end
      pend.delete();
      repeat (TO + 20) @(negedge clk);

      // Start-bit glitch is not counted
      RX = 1'b0;
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_rdy", 32'(cmd_rdy), 32'd0);
      c = 24'($urandom);
      send_cmd(c);
      clear_rdy();

      // Clear in the completion cycle loses to completion
      c = 24'($urandom);
      rx_byte(c[23:16], 1'b1, 0);
      rx_byte(c[15:8], 1'b1, 0);
      e0 = cyc + 1;
      fork
         send_byte(c[7:0], 1'b1, 4);
         begin
            repeat (154) @(negedge clk);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
         end
      join
      model_byte(c[7:0], 1'b1);
      chk("clr_vs_done_when", 32'(rise_cyc), 32'(e0 + 2 + 9 * BD + BD / 2));
      check_model("clr_vs_done");
      // A fourth byte while pending is dropped
      rx_byte(8'($urandom_range(0, 255)), 1'b1, 4);
      chk("cmd_unchanged", 32'(cmd), 32'(c));
      clear_rdy();
      c = 24'($urandom);
      send_cmd(c);
      clear_rdy();

      // Reset in the middle of a TX frame and a partial RX command
      b1 = 8'($urandom_range(1, 255));
      rx_byte(b1, 1'b1, 0);
      c[7:0] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 88; k++) begin
         if (k == 0) begin resp = 8'h3C; send_resp = 1'b1; end
         if (k == 1) send_resp = 1'b0;
         RX = frame_bit(c[7:0], k / BD);
         @(negedge clk);
      end
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      rst = 1'b1;
      RX = 1'b1;
      @(negedge clk);
      pend.delete();
      model_rdy = 1'b0;
      model_cmd = 24'h0;
      chk("mid_rst_tx", 32'(TX), 32'd1);
      chk("mid_rst_busy", 32'(tx_busy), 32'd0);
      chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
      chk("mid_rst_cmd", 32'(cmd), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      c = 24'($urandom);
      send_cmd(c);
      chk("post_rst_cmd", 32'(cmd), 32'(c));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   function automatic logic [7:0] ACK_BYTE();
      return dso_uart_pkg::ACK;
   endfunction

endmodule

// File: doc/uart_cmd_slave.md
# uart_cmd_slave

Device-side UART endpoint of the DSO host link. It receives the 3-byte host commands serially on RX (opcode first) and assembles them into one 24-bit `cmd` word, raising `cmd_rdy` when the word is complete. It also transmits single-byte responses (ack 0xA5, EEP data, trig config, dump samples) back to the host on TX. It sits between the board UART pins and the DSO_dig command processor.

## Interface
- BAUD_DIV, 108: clk cycles per bit; must be ≥ 8.
- TIMEOUT_BAUDS, 32: idle bit-times after which a partial command is discarded.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- RX  in  1  serial from host; idle high; asynchronous to clk.
- TX  out  1  serial to host; idle high.
- cmd  out  24  assembled command; byte 0 in [23:16], byte 1 in [15:8], byte 2 in [7:0].
- cmd_rdy  out  1  complete command held in `cmd`.
- clr_cmd_rdy  in  1  consumer clears `cmd_rdy`.
- resp  in  8  response byte.
- send_resp  in  1  one-cycle request to transmit `resp`.
- tx_busy  out  1  transmitter active.
- resp_sent  out  1  one-cycle pulse when a response frame has completed.
- frame_err  out  1  one-cycle pulse when a received stop bit is low.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX path: RX passes through a 2-flop synchronizer. Receiver states are IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - At mid-start (BAUD_DIV/2 cycles), a high line means a glitch: return to IDLE and count nothing.
  - Each data bit is sampled at the middle of its bit period, BAUD_DIV apart.
  - STOP sampled high: the byte is valid. STOP sampled low: `frame_err` pulses, the byte is dropped, and the byte counter is reset to 0.
- Assembler: a 2-bit byte counter runs 0→1→2. Each valid byte shifts into `cmd` at the slot given by the counter.
  - The third byte sets `cmd_rdy`, and the counter returns to 0.
  - `cmd` stays stable while `cmd_rdy` is high.
  - Bytes that arrive while `cmd_rdy` is high are discarded and do not advance the counter.
- Inter-byte timeout: with the counter ≠ 0 and the receiver in IDLE for TIMEOUT_BAUDS×BAUD_DIV cycles, the counter resets to 0. `cmd` keeps its last value.
- Simultaneous third-byte completion and `clr_cmd_rdy`: completion wins, so `cmd_rdy` stays 1.
- TX path: transmitter states are IDLE, START, DATA, STOP.
  - `send_resp` in IDLE latches `resp` and starts a frame.
  - `send_resp` while `tx_busy` is ignored; no queueing.
  - TX and RX operate fully independently (full duplex).
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frame_err=0, byte counter=0, both state machines in IDLE. Reset mid-frame aborts the frame and discards any partial command.

## Timing
- RX latency: `cmd_rdy` rises 1 cycle after the cycle in which the third byte's stop bit is sampled. That sample point is 2 synchronizer cycles plus 9.5×BAUD_DIV cycles after the start-bit falling edge.
- `cmd_rdy` falls 1 cycle after `clr_cmd_rdy` is sampled high.
- TX: TX drives the start bit from the cycle after `send_resp`. Each bit lasts exactly BAUD_DIV cycles.
- `tx_busy` is high from the cycle after `send_resp` for 10×BAUD_DIV cycles.
- `resp_sent` pulses in the first cycle after the stop bit ends, with `tx_busy` already 0. A new `send_resp` is accepted in that same cycle.
- All outputs are registered.

## Structure
- Shared package `dso_uart_pkg`:
  - Opcode constants DUMP_CH=0x01, CFG_GAIN=0x02, TRIG_LVL=0x03, TRIG_POS=0x04, SET_DEC=0x05, TRIG_CFG=0x06, TRIG_RD=0x07, EEP_WRT=0x08, EEP_RD=0x09.
  - ACK=0xA5.
  - Default BAUD_DIV.
  - The receiver and transmitter state enums.
- One sub-module `uart_byte_tx` containing the transmit state machine, baud counter and shift register. Receiver, assembler and timeout stay in the top module.

## Test plan
Run all scenarios with BAUD_DIV=16 and TIMEOUT_BAUDS=32.
- Send 0x08, 0x2A, 0xBB → `cmd`=0x082ABB; `cmd_rdy`=1 at the stop-sample cycle +1; held until `clr_cmd_rdy`, then 0 one cycle later.
- Pulse `send_resp` with `resp`=0xA5 → TX bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles; `resp_sent` pulses at cycle 161; a second `send_resp` at cycle 50 is ignored.
- Send 0x05, then 0xFF with a low stop bit → `frame_err` pulses once, no `cmd_rdy`. Then send 0x05, 0xFF, 0x02 → `cmd`=0x05FF02.
- Send 0x01, wait 600 cycles, send 0x07, 0xBA, 0xE0 → `cmd`=0x07BAE0 (the stale 0x01 was discarded).
- RX low for 4 cycles only → no byte is counted. `clr_cmd_rdy` asserted in the same cycle as third-byte completion → `cmd_rdy`=1. A fourth byte sent while `cmd_rdy`=1 → `cmd` is unchanged.
- Assert `rst` mid-TX (bit 4) and mid-RX (byte 2) → next cycle TX=1, `tx_busy`=0, `cmd_rdy`=0, `cmd`=0. A following full command assembles correctly.
